// File: rtl/fuzz_vector_sequencer.sv
// fuzz_vector_sequencer: queues stimulus vectors, replays each to a DUT for a programmable hold window plus zero gap, folds DUT responses into a signature.
// Latency: first vector appears on dut_in the cycle after the start edge; dut_y is captured at the closing edge of each hold window.
// Backpressure: vec_ready = !full from registered occupancy; a full FIFO refuses a push even when a pop happens in the same cycle.
//
// Ports:
//   clk, rst                 sole clock, synchronous active-high reset
//   vec_valid/vec_data/vec_ready  stimulus push interface (wire0 in MSBs .. wire4 in LSBs)
//   start, hold_cycles, zero_gap  run control; hold/gap relatched at every pop
//   dut_in                   registered drive to the DUT input bundle
//   dut_y                    DUT response, sampled at capture
//   sig, vec_count           running signature and saturating capture count
//   busy, done               not-IDLE flag and one-cycle end-of-run pulse

module fuzz_vector_sequencer #(
  parameter int DEPTH = 8,
  parameter int VEC_W = 84,
  parameter int Y_W   = 119
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vec_valid,
  input  logic [VEC_W-1:0] vec_data,
  output logic             vec_ready,
  input  logic             start,
  input  logic [3:0]       hold_cycles,
  input  logic [1:0]       zero_gap,
  output logic [VEC_W-1:0] dut_in,
  input  logic [Y_W-1:0]   dut_y,
  output logic [31:0]      sig,
  output logic [7:0]       vec_count,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_ZERO  = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;      // cycles remaining in current APPLY/ZERO window, minus one
  logic [1:0]       r_gap;      // zero_gap latched at the last pop
  logic [VEC_W-1:0] r_dut_in;
  logic [31:0]      r_sig;
  logic [7:0]       r_vec_count;

  logic             w_empty;
  logic [VEC_W-1:0] w_head;
  logic             w_cap;
  logic             w_next;
  logic             w_advance;
  logic             w_pop;
  logic [3:0]       w_hold_m1;
  logic [127:0]     w_y_ext;
  logic [31:0]      w_fold;

  fvs_fifo #(
    .W     (VEC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push_vld (vec_valid),
    .i_push_dat (vec_data),
    .o_push_rdy (vec_ready),
    .i_pop      (w_pop),
    .o_pop_dat  (w_head),
    .o_empty    (w_empty)
  );

  // Hold of 0 behaves as 1, so the counter preload is max(h,1)-1.
  assign w_hold_m1 = (hold_cycles == 4'd0) ? 4'd0 : hold_cycles - 4'd1;

  assign w_y_ext = 128'(dut_y);
  assign w_fold  = w_y_ext[127:96] ^ w_y_ext[95:64] ^ w_y_ext[63:32] ^ w_y_ext[31:0];

  assign w_cap = (r_state == S_APPLY) && (r_cnt == 4'd0);
  // Next-vector decision: end of ZERO, or capture itself when there is no gap.
  assign w_next    = (w_cap && (r_gap == 2'd0)) || ((r_state == S_ZERO) && (r_cnt == 4'd0));
  assign w_advance = ((r_state == S_IDLE) && start) || w_next;
  assign w_pop     = w_advance && !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_gap       <= 2'd0;
      r_dut_in    <= '0;
      r_sig       <= 32'd0;
      r_vec_count <= 8'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sig       <= 32'd0;
            r_vec_count <= 8'd0;
          end
        end
        S_APPLY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_sig <= {r_sig[30:0], r_sig[31]} ^ w_fold;
            if (r_vec_count != 8'hFF) r_vec_count <= r_vec_count + 8'd1;
            if (r_gap != 2'd0) begin
              r_state  <= S_ZERO;
              r_dut_in <= '0;
              r_cnt    <= {2'b00, r_gap} - 4'd1;
            end
          end
        end
        S_ZERO: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Shared hand-off: load the next vector or finish the run.
      if (w_advance) begin
        if (!w_empty) begin
          r_state  <= S_APPLY;
          r_dut_in <= w_head;
          r_cnt    <= w_hold_m1;
          r_gap    <= zero_gap;
        end else begin
          r_state  <= S_FIN;
          r_dut_in <= '0;
        end
      end
    end
  end

  assign dut_in    = r_dut_in;
  assign sig       = r_sig;
  assign vec_count = r_vec_count;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);

endmodule

// fvs_fifo: generic power-of-two FIFO with registered occupancy.
// Latency: pushed word visible at o_pop_dat the cycle after the push edge (if it is the head).
// Backpressure: o_push_rdy = !full from registered count only; pops never free space the same cycle.
//
// Ports: push valid/data/ready, pop strobe with head data, empty flag.
module fvs_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push_vld,
  input  logic [W-1:0] i_push_dat,
  output logic         o_push_rdy,
  input  logic         i_pop,
  output logic [W-1:0] o_pop_dat,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;   // one extra bit so 0 and DEPTH never alias
  logic          w_push;
  logic          w_pop;

  assign o_push_rdy = (r_count != FULL_CNT);
  assign o_empty    = (r_count == '0);
  assign w_push     = i_push_vld && o_push_rdy;
  assign w_pop      = i_pop && !o_empty;
  assign o_pop_dat  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: tb/tb_fuzz_vector_sequencer.sv
// tb_fuzz_vector_sequencer: randomized replay runs checked cycle by cycle against a queue-based model.
// Latency: model expects first vector one cycle after the start edge, done one cycle after the last capture or gap.
// Backpressure: model tracks FIFO fill to predict vec_ready, including the full-with-pop corner.

module tb_fuzz_vector_sequencer;

  localparam int DEPTH = 8;
  localparam int VEC_W = 84;
  localparam int Y_W   = 119;

  logic             clk = 1'b0;
  logic             rst;
  logic             vec_valid;
  logic [VEC_W-1:0] vec_data;
  logic             vec_ready;
  logic             start;
  logic [3:0]       hold_cycles;
  logic [1:0]       zero_gap;
  logic [VEC_W-1:0] dut_in;
  logic [Y_W-1:0]   dut_y;
  logic [31:0]      sig;
  logic [7:0]       vec_count;
  logic             busy;
  logic             done;

  int n_vectors = 0;
  int n_miscompares = 0;

  logic [VEC_W-1:0] mq[$];   // model of FIFO contents

  fuzz_vector_sequencer #(
    .DEPTH (DEPTH),
    .VEC_W (VEC_W),
    .Y_W   (Y_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vec_valid   (vec_valid),
    .vec_data    (vec_data),
    .vec_ready   (vec_ready),
    .start       (start),
    .hold_cycles (hold_cycles),
    .zero_gap    (zero_gap),
    .dut_in      (dut_in),
    .dut_y       (dut_y),
    .sig         (sig),
    .vec_count   (vec_count),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[VEC_W-1:0];
  endfunction

  function automatic logic [Y_W-1:0] rand_y();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[Y_W-1:0];
  endfunction

  // Response fold: zero-extend to 128 bits and XOR the four 32-bit words.
  function automatic logic [31:0] fold(input logic [Y_W-1:0] y);
    logic [127:0] z;
    z = '0;
    z[Y_W-1:0] = y;
    return z[127:96] ^ z[95:64] ^ z[63:32] ^ z[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_vec(input logic [VEC_W-1:0] v);
    logic exp_rdy;
    exp_rdy = (mq.size() < DEPTH);
    n_vectors++;
    if (vec_ready !== exp_rdy) begin
      n_miscompares++;
      $display("FAIL push_ready: got %b, required %b", vec_ready, exp_rdy);
    end
    vec_valid = 1'b1;
    vec_data  = v;
    tick();
    if (exp_rdy) mq.push_back(v);
  endtask

  // Start a run over the model queue and check every cycle until back in IDLE.
  task automatic run_check(input string name, input int h, input int g, input bit y_ones,
                           input bit hold_start, input bit late_push,
                           input logic [VEC_W-1:0] late_vec);
    logic [VEC_W-1:0] ed[$];
    bit               ec[$];
    bit               ef[$];
    int               heff;
    logic [31:0]      msig;
    int               mcnt;
    logic [Y_W-1:0]   y;
    logic [VEC_W+41:0] obs;
    logic [VEC_W+41:0] exp;
    bit               is_idle;

    if (late_push) mq.push_back(late_vec);
    heff = (h == 0) ? 1 : h;
    foreach (mq[i]) begin
      for (int j = 0; j < heff; j++) begin
        ed.push_back(mq[i]); ec.push_back(j == heff - 1); ef.push_back(1'b0);
      end
      for (int j = 0; j < g; j++) begin
        ed.push_back('0); ec.push_back(1'b0); ef.push_back(1'b0);
      end
    end
    ed.push_back('0); ec.push_back(1'b0); ef.push_back(1'b1);
    mq.delete();

    hold_cycles = 4'(h);
    zero_gap    = 2'(g);
    start       = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    msig = 32'd0;
    mcnt = 0;

    for (int k = 0; k <= ed.size(); k++) begin
      is_idle = (k == ed.size());
      exp = {(is_idle ? {VEC_W{1'b0}} : ed[k]), (is_idle ? 1'b0 : ef[k]), !is_idle, msig, 8'(mcnt)};
      obs = {dut_in, done, busy, sig, vec_count};
      n_vectors++;
      if (obs !== exp) begin
        n_miscompares++;
        $display("FAIL %s cyc%0d: got din=%h done=%b busy=%b sig=%h cnt=%0d, required din=%h done=%b busy=%b sig=%h cnt=%0d",
                 name, k, dut_in, done, busy, sig, vec_count,
                 exp[VEC_W+41:42], exp[41], exp[40], exp[39:8], exp[7:0]);
      end
      if (late_push && k == 0) begin
        n_vectors++;
        if (vec_ready !== 1'b1) begin
          n_miscompares++;
          $display("FAIL %s ready_after_pop: got %b, required 1", name, vec_ready);
        end
      end
      if (late_push && k == 1) begin
        n_vectors++;
        if (vec_ready !== 1'b0) begin
          n_miscompares++;
          $display("FAIL %s ready_refull: got %b, required 0", name, vec_ready);
        end
        vec_valid = 1'b0;
      end
      if (k == ed.size() - 1) start = 1'b0;
      y = y_ones ? {Y_W{1'b1}} : rand_y();
      dut_y = y;
      if (!is_idle && ec[k]) begin
        msig = {msig[30:0], msig[31]} ^ fold(y);
        if (mcnt < 255) mcnt++;
      end
      if (!is_idle) tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; vec_valid = 1'b0; vec_data = '0; start = 1'b0;
    hold_cycles = 4'd0; zero_gap = 2'd0; dut_y = '0;
    repeat (3) tick();
    n_vectors++;
    if ({dut_in, sig, vec_count, done, busy} !== '0) begin
      n_miscompares++;
      $display("FAIL reset_state: got din=%h sig=%h cnt=%0d done=%b busy=%b, required all 0",
               dut_in, sig, vec_count, done, busy);
    end
    rst = 1'b0;
    tick();
    n_vectors++;
    if (vec_ready !== 1'b1) begin
      n_miscompares++;
      $display("FAIL reset_ready: got %b, required 1", vec_ready);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) push_vec(rand_vec());
    vec_valid = 1'b0;
    run_check("back_to_back", 1, 0, 1'b0, 1'b0, 1'b0, '0);
    n_vectors++;
    if (vec_count !== 8'd3) begin
      n_miscompares++;
      $display("FAIL b2b_count: got %0d, required 3", vec_count);
    end
  endtask

  task automatic test_hold_gap();
    push_vec(rand_vec());
    vec_valid = 1'b0;
    run_check("hold3_gap2", 3, 2, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_signature();
    for (int i = 0; i < 2; i++) push_vec(rand_vec());
    vec_valid = 1'b0;
    run_check("sig_ones", 1, 1, 1'b1, 1'b0, 1'b0, '0);
    n_vectors++;
    if (sig !== 32'h00800001) begin
      n_miscompares++;
      $display("FAIL sig_const: got %h, required 00800001", sig);
    end
  endtask

  task automatic test_empty_start();
    run_check("empty_start", 2, 1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_fill();
    logic [VEC_W-1:0] v9;
    for (int i = 0; i < DEPTH; i++) push_vec(rand_vec());
    v9 = rand_vec();
    vec_data = v9;
    for (int i = 0; i < 3; i++) begin
      n_vectors++;
      if (vec_ready !== 1'b0) begin
        n_miscompares++;
        $display("FAIL full_ready: got %b, required 0", vec_ready);
      end
      tick();
    end
    run_check("fill_late", 4, 1, 1'b0, 1'b0, 1'b1, v9);
  endtask

  task automatic test_random();
    int n, h, g;
    bit hs;
    for (int r = 0; r < 6; r++) begin
      n  = $urandom_range(1, DEPTH);
      h  = $urandom_range(0, 15);
      g  = $urandom_range(0, 3);
      hs = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) push_vec(rand_vec());
      vec_valid = 1'b0;
      run_check("random", h, g, 1'b0, hs, 1'b0, '0);
    end
  endtask

  task automatic test_reset_midrun();
    logic [VEC_W-1:0] v2;
    for (int i = 0; i < 4; i++) push_vec(rand_vec());
    vec_valid = 1'b0;
    v2 = mq[1];
    hold_cycles = 4'd2; zero_gap = 2'd1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    n_vectors++;
    if (dut_in !== v2) begin
      n_miscompares++;
      $display("FAIL midrun_v2: got %h, required %h", dut_in, v2);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mq.delete();
    n_vectors++;
    if ({dut_in, busy, vec_ready, done} !== {{VEC_W{1'b0}}, 1'b0, 1'b1, 1'b0}) begin
      n_miscompares++;
      $display("FAIL midrun_abort: got din=%h busy=%b rdy=%b done=%b, required 0/0/1/0",
               dut_in, busy, vec_ready, done);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vectors++;
      if ({done, busy} !== 2'b00) begin
        n_miscompares++;
        $display("FAIL midrun_quiet: got done=%b busy=%b, required 0 0", done, busy);
      end
    end
    run_check("post_reset_empty", 1, 0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_hold_gap();
    test_signature();
    test_empty_start();
    test_fill();
    test_random();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/fuzz_vector_sequencer.md
FUZZ_VECTOR_SEQUENCER -- requirements
Module: fuzz_vector_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: stimulus FIFO depth in vectors, power of two, 2..64.
REQ-002 SHALL have parameter VEC_W, default 84: DUT input bundle width, equal to 19+20+18+12+15 for {wire0,wire1,wire2,wire3,wire4}.
REQ-003 SHALL have parameter Y_W, default 119: DUT output width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port vec_valid  input  1  stimulus vector offered.
REQ-007 SHALL have port vec_data  input  VEC_W  stimulus vector; wire0 in MSBs, wire4 in LSBs.
REQ-008 SHALL have port vec_ready  output  1  FIFO can accept a vector.
REQ-009 SHALL have port start  input  1  begin a run over the queued vectors.
REQ-010 SHALL have port hold_cycles  input  4  cycles each vector is driven; 0 is treated as 1.
REQ-011 SHALL have port zero_gap  input  2  all-zero cycles inserted after each vector.
REQ-012 SHALL have port dut_in  output  VEC_W  registered drive to the DUT input bundle.
REQ-013 SHALL have port dut_y  input  Y_W  DUT output, sampled at capture.
REQ-014 SHALL have port sig  output  32  running response signature.
REQ-015 SHALL have port vec_count  output  8  vectors captured this run, saturating at 255.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse at end of run.

Function
REQ-018 SHALL accept a push when vec_valid && vec_ready; vec_ready = !full, from registered occupancy only, so no push is accepted when full even if a pop occurs that cycle.
REQ-019 SHALL accept pushes in every state; a vector pushed before the next-vector decision is consumed in the same run.
REQ-020 SHALL implement the FSM states IDLE, APPLY, ZERO, FIN.
REQ-021 In IDLE with start=1 and FIFO non-empty at edge T, SHALL pop the head, latch hold_cycles and zero_gap, clear sig and vec_count, and enter APPLY with dut_in = head vector from T+1.
REQ-022 In IDLE with start=1 and FIFO empty, SHALL enter FIN directly; sig and vec_count are cleared.
REQ-023 SHALL hold dut_in for exactly max(latched hold_cycles,1) cycles in APPLY.
REQ-024 On the final APPLY cycle, SHALL sample dut_y at that closing edge: sig <= {sig[30:0],sig[31]} XOR (XOR of the four 32-bit slices of dut_y zero-extended to 128 bits); vec_count increments, saturating at 255.
REQ-025 After capture SHALL enter ZERO with dut_in = 0 for the latched zero_gap cycles; when zero_gap=0, ZERO is skipped.
REQ-026 At the end of ZERO, or at capture when zero_gap=0, SHALL pop the next vector into APPLY if the FIFO is non-empty, else enter FIN; hold_cycles and zero_gap are relatched at each pop.
REQ-027 FIN SHALL last one cycle with done=1, dut_in=0, then return to IDLE; sig and vec_count hold until the next accepted start.
REQ-028 SHALL ignore start in any state other than IDLE.
REQ-029 The FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH without aliasing.

Reset
REQ-030 While rst=1 SHALL force state IDLE, FIFO empty, dut_in=0, sig=0, vec_count=0, done=0, busy=0; vec_ready=1 from the first cycle after rst deasserts.
REQ-031 rst asserted mid-run SHALL abort at that edge, discarding queued vectors with no done pulse.

Verification
REQ-032 Bench SHALL push 3 vectors, hold_cycles=1, zero_gap=0, start -> dut_in shows each vector for 1 cycle back-to-back; done 1 cycle after third capture; vec_count=3.
REQ-033 Bench SHALL push 1 vector, hold_cycles=3, zero_gap=2 -> dut_in = vector for 3 cycles, then 0 for 2 cycles, then FIN; done exactly 6 cycles after start edge.
REQ-034 Bench SHALL drive dut_y = all-ones over 2 vectors -> fold = 32'h007FFFFF^0xFFFFFFFF^…, i.e. slice XOR 32'hFF800000; sig after vector 1 = 32'hFF800000, after vector 2 = 32'hFF000001 ^ 32'hFF800000 = 32'h00800001.
REQ-035 Bench SHALL fill the FIFO to DEPTH with vec_valid held high -> vec_ready=0; the 9th vector is not accepted and is accepted only after a pop.
REQ-036 Bench SHALL start with an empty FIFO -> done pulses at T+1, vec_count=0, sig=0.
REQ-037 Bench SHALL assert rst during APPLY of the second of 4 vectors -> next cycle dut_in=0, busy=0, vec_ready=1, no done pulse; a new start with an empty FIFO yields only FIN.
